// File: rtl/tohost_reporter.sv
// tohost_reporter
// Memory-mapped test-status device for the riscv-tests `tohost` convention.
// A full-word store to TOHOST_ADDR while running is decoded into
// pass/fail flags, a failing-test number and a frozen cycle count.
//
// Parameters:
//   TOHOST_ADDR    byte address of the tohost word (word aligned)
//   TIMEOUT_TICKS  watchdog limit in clock cycles (>= 2)
// Optional feature:
//   `define TOHOST_REPORTER_WATCHDOG_EN  enables the watchdog (TMO state);
//   when undefined, timeout stays 0 and cycles free-runs with wrap.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   wr_en      store strobe
//   wr_addr    store byte address
//   wr_data    store data
//   wr_strb    store byte enables
//   rd_en      load strobe
//   rd_addr    load byte address
//   rd_data    registered load data (holds when rd_en is low)
//   done       test finished (pass, fail or timeout)
//   passed     test passed
//   timeout    watchdog expired
//   fail_code  failing test number, tohost[31:1]; zero unless failed
//   halt       stall request to the core, equal to done
//   cycles     cycles spent running
module tohost_reporter #(
  parameter logic [31:0] TOHOST_ADDR   = 32'h0000_1000,
  parameter int unsigned TIMEOUT_TICKS = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic        rd_en,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        passed,
  output logic        timeout,
  output logic [30:0] fail_code,
  output logic        halt,
  output logic [31:0] cycles
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2,
    TMO  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] tohost_q;
  logic        running;
  logic        wr_accept;
  logic        wr_terminal;
  logic        wd_expire;
  logic [31:0] status_word;

  assign running     = (state == RUN);
  assign wr_accept   = running && wr_en && (wr_addr == TOHOST_ADDR) && (wr_strb == 4'hf);
  // Odd data ends the test; even data (syscall or zero) keeps running.
  assign wr_terminal = wr_accept && wr_data[0];
  assign status_word = {28'b0, timeout, passed, done, running};

`ifdef TOHOST_REPORTER_WATCHDOG_EN
  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_TICKS - 1);
  assign wd_expire = (cycles == WD_LIMIT);
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      tohost_q  <= '0;
      cycles    <= '0;
      rd_data   <= '0;
      done      <= 1'b0;
      passed    <= 1'b0;
      timeout   <= 1'b0;
      fail_code <= '0;
      halt      <= 1'b0;
    end else begin
      // Read decode uses pre-edge state, so a same-cycle write to tohost
      // is not visible until the following read.
      if (rd_en) begin
        if (rd_addr == TOHOST_ADDR)
          rd_data <= tohost_q;
        else if (rd_addr == TOHOST_ADDR + 32'd4)
          rd_data <= status_word;
        else if (rd_addr == TOHOST_ADDR + 32'd8)
          rd_data <= cycles;
        else
          rd_data <= '0;
      end

      if (running) begin
        if (wr_accept)
          tohost_q <= wr_data;

        // A terminal write beats a watchdog expiry in the same cycle.
        if (wr_terminal) begin
          cycles <= cycles + 32'd1;
          done   <= 1'b1;
          halt   <= 1'b1;
          if (wr_data == 32'h1) begin
            state  <= PASS;
            passed <= 1'b1;
          end else begin
            state     <= FAIL;
            fail_code <= wr_data[31:1];
          end
        end else if (wd_expire) begin
          // cycles is deliberately not advanced: it freezes at the limit.
          state   <= TMO;
          done    <= 1'b1;
          halt    <= 1'b1;
          timeout <= 1'b1;
        end else begin
          cycles <= cycles + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tohost_reporter.sv
module tb_tohost_reporter;

  localparam logic [31:0] A   = 32'h0000_1000;
  localparam int unsigned TMO = 20;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        done;
  logic        passed;
  logic        timeout;
  logic [30:0] fail_code;
  logic        halt;
  logic [31:0] cycles;

  tohost_reporter #(.TOHOST_ADDR(A), .TIMEOUT_TICKS(TMO)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .done(done), .passed(passed), .timeout(timeout),
    .fail_code(fail_code), .halt(halt), .cycles(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] cyc;
    logic        dn;
    logic        ps;
    logic        to;
    logic        ht;
    logic [30:0] code;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef TOHOST_REPORTER_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  // Reference model: test outcome described as "finished", "ok", "timed out"
  // plus the stored tohost word and counters.
  bit          m_fin, m_ok, m_to;
  logic [30:0] m_code;
  logic [31:0] m_tohost, m_cyc, m_rd;

  task automatic model_step(input logic r, input logic we, input logic [31:0] wa,
                            input logic [31:0] wd, input logic [3:0] ws,
                            input logic re, input logic [31:0] ra);
    logic [31:0] status;
    if (!r) begin
      m_fin = 0; m_ok = 0; m_to = 0; m_code = '0;
      m_tohost = '0; m_cyc = '0; m_rd = '0;
    end else begin
      status = {28'b0, m_to, m_ok, m_fin, ~m_fin};
      if (re) begin
        if (ra == A)                m_rd = m_tohost;
        else if (ra == A + 32'd4)   m_rd = status;
        else if (ra == A + 32'd8)   m_rd = m_cyc;
        else                        m_rd = 32'h0;
      end
      if (!m_fin) begin
        if (we && wa == A && ws == 4'hf) begin
          m_tohost = wd;
          if (wd == 32'h1) begin
            m_fin = 1; m_ok = 1;
          end else if (wd[0]) begin
            m_fin = 1; m_code = wd[31:1];
          end
        end
        if (m_fin) m_cyc = m_cyc + 1;
        else if (WD && m_cyc == TMO - 1) begin
          m_fin = 1; m_to = 1;
        end else m_cyc = m_cyc + 1;
      end
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [31:0] wa,
                       input logic [31:0] wd, input logic [3:0] ws,
                       input logic re, input logic [31:0] ra);
    exp_t e;
    @(negedge clk);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; wr_strb = ws;
    rd_en = re; rd_addr = ra;
    model_step(r, we, wa, wd, ws, re, ra);
    e.rd = m_rd; e.cyc = m_cyc; e.dn = m_fin; e.ps = m_ok; e.to = m_to;
    e.ht = m_fin; e.code = m_code;
    q.push_back(e);
  endtask

  task automatic reset_dut();
    drive(1'b0, 1'b0, '0, '0, 4'h0, 1'b0, '0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0, '0, 4'h0, 1'b0, '0);
  endtask
  task automatic wr(input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws);
    drive(1'b1, 1'b1, wa, wd, ws, 1'b0, '0);
  endtask
  task automatic rd(input logic [31:0] ra);
    drive(1'b1, 1'b0, '0, '0, 4'h0, 1'b1, ra);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: one expected record per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("rd_data",   rd_data,          e.rd);
        check("cycles",    cycles,           e.cyc);
        check("done",      {31'b0, done},    {31'b0, e.dn});
        check("passed",    {31'b0, passed},  {31'b0, e.ps});
        check("timeout",   {31'b0, timeout}, {31'b0, e.to});
        check("halt",      {31'b0, halt},    {31'b0, e.ht});
        check("fail_code", {1'b0, fail_code}, {1'b0, e.code});
      end
    end
  end

  initial begin
    logic [31:0] d, a, r32;
    logic [3:0]  s;
    int          len;
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rd_en = 1'b0; rd_addr = '0;

    // Pass written on the 10th cycle after reset.
    reset_dut(); reset_dut();
    idle(9);
    wr(A, 32'h1, 4'hf);
    rd(A + 32'd4); rd(A + 32'd8); rd(A);

    // Fail with code 3; later pass write ignored.
    reset_dut();
    wr(A, 32'h7, 4'hf);
    wr(A, 32'h1, 4'hf);
    rd(A); rd(A + 32'd4);

    // Partial strobe, wrong address, then syscall value.
    reset_dut();
    wr(A, 32'h1, 4'h1);
    wr(A + 32'd4, 32'h1, 4'hf);
    wr(A, 32'h2, 4'hf);
    rd(A); rd(A + 32'd4); rd(A + 32'd12);

    // Same-cycle read and write of tohost returns the old value.
    drive(1'b1, 1'b1, A, 32'h4, 4'hf, 1'b1, A);
    rd(A);

    if (WD) begin
      reset_dut();
      idle(TMO + 2);
      rd(A + 32'd4); rd(A + 32'd8);
      // Pass written on the expiry cycle wins.
      reset_dut();
      idle(TMO - 1);
      wr(A, 32'h1, 4'hf);
      rd(A + 32'd4);
    end else begin
      reset_dut();
      idle(100);
      rd(A + 32'd8);
    end

    // Reset out of FAIL, then pass.
    reset_dut();
    wr(A, 32'h9, 4'hf);
    reset_dut();
    wr(A, 32'h1, 4'hf);

    // Randomized runs.
    for (int it = 0; it < 40; it++) begin
      reset_dut();
      len = $urandom_range(50, 5);
      for (int k = 0; k < len; k++) begin
        r32 = $urandom();
        case ($urandom_range(3, 0))
          0: a = A;
          1: a = A + 32'd4;
          2: a = A + 32'd8;
          default: a = r32 & 32'hffff_fffc;
        endcase
        case ($urandom_range(9, 0))
          0: d = 32'h1;
          1: d = r32 | 32'h1;
          2: d = 32'h0;
          default: d = r32 & 32'hffff_fffe;
        endcase
        s = ($urandom_range(3, 0) == 0) ? 4'($urandom()) : 4'hf;
        if ($urandom_range(19, 0) == 0)
          drive(1'b0, 1'b0, '0, '0, 4'h0, 1'b0, '0);
        else
          drive(1'b1, $urandom_range(2, 0) == 0, a, d, s,
                $urandom_range(1, 0) == 1, a);
      end
    end

    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #5;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
